// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared constants, FIFO entry layout and feeder state type
package cipher_pkg;

  localparam logic [7:0] CHAR_A      = 8'h41;
  localparam logic [7:0] CHAR_Z      = 8'h5A;
  localparam logic [7:0] CHAR_LA     = 8'h61;
  localparam logic [7:0] CHAR_LZ     = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  localparam int KEY_LEN_DEFAULT = 10;
  localparam int ENTRY_W         = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DONE
  } feeder_state_t;

  // data=0 marks an end-of-message marker carrying no character
  typedef struct packed {
    logic [7:0] ch;
    logic       last;
    logic       data;
  } fifo_entry_t;

endpackage

// File: rtl/feeder_fifo.sv
// rtl/feeder_fifo.sv - DEPTH x WIDTH synchronous FIFO with full/empty flags
module feeder_fifo
  import cipher_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cipher_feeder.sv
// rtl/cipher_feeder.sv - filters ASCII into uppercase letters and feeds a Vigenere stage
// Optional CIPHER_FEEDER_CASE_FOLD_EN folds 'a'..'z' to uppercase instead of dropping them.
module cipher_feeder
  import cipher_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int KEY_LEN = KEY_LEN_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] in_char,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] plain_char,
  output logic       plain_valid,
  input  logic       plain_ready,
  output logic       key_load,
  output logic [3:0] key_index,
  output logic       msg_done,
  output logic [7:0] err_count
);

  localparam logic [3:0] KEY_IDX_MAX = 4'(KEY_LEN - 1);

  feeder_state_t state;
  feeder_state_t state_next;
  fifo_entry_t   push_entry;
  fifo_entry_t   head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          accept;
  logic          char_ok;
  logic [7:0]    stored_char;

  always_comb begin
    char_ok     = (in_char >= CHAR_A) && (in_char <= CHAR_Z);
    stored_char = in_char;
`ifdef CIPHER_FEEDER_CASE_FOLD_EN
    if ((in_char >= CHAR_LA) && (in_char <= CHAR_LZ)) begin
      char_ok     = 1'b1;
      stored_char = in_char - CASE_OFFSET;
    end
`endif
  end

  assign in_ready  = reset_n && !fifo_full;
  assign accept    = in_valid && in_ready;
  // A dropped character still has to close its message if it carried last
  assign fifo_push = accept && (char_ok || in_last);
  assign push_entry = char_ok ? '{ch: stored_char, last: in_last, data: 1'b1}
                              : '{ch: 8'h00, last: 1'b1, data: 1'b0};

  feeder_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (accept && !char_ok && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    key_load    = 1'b0;
    plain_valid = 1'b0;
    msg_done    = 1'b0;
    fifo_pop    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        key_load   = 1'b1;
        state_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (!fifo_empty) begin
          if (head.data) begin
            plain_valid = 1'b1;
            fifo_pop    = plain_ready;
          end else begin
            fifo_pop = 1'b1;
          end
          if (fifo_pop && head.last) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        msg_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign plain_char = plain_valid ? head.ch : 8'h00;

  // Index is held at 0 outside STREAM so every message starts from key position 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_index <= '0;
    end else if (state != ST_STREAM) begin
      key_index <= '0;
    end else if (fifo_pop && head.data) begin
      key_index <= (key_index == KEY_IDX_MAX) ? 4'd0 : key_index + 4'd1;
    end
  end

endmodule

// File: tb/tb_cipher_feeder.sv
// tb/tb_cipher_feeder.sv - self-checking bench for cipher_feeder
module tb_cipher_feeder;

  localparam int DEPTH   = 8;
  localparam int KEY_LEN = 10;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] plain_char;
  logic       plain_valid;
  logic       plain_ready;
  logic       key_load;
  logic [3:0] key_index;
  logic       msg_done;
  logic [7:0] err_count;

  cipher_feeder #(.DEPTH(DEPTH), .KEY_LEN(KEY_LEN)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_char     (in_char),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .plain_char  (plain_char),
    .plain_valid (plain_valid),
    .plain_ready (plain_ready),
    .key_load    (key_load),
    .key_index   (key_index),
    .msg_done    (msg_done),
    .err_count   (err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] ch;
    logic [3:0] idx;
  } out_t;

  typedef struct {
    logic [7:0] ch;
    logic       exp_out;
    logic [7:0] exp_char;
    logic       exp_err;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  out_t       exp_q[$];
  int         cur_pos = 0;
  int         exp_msgs = 0;
  int         exp_err = 0;
  int         load_cnt = 0;
  int         done_cnt = 0;
  int         pop_cnt = 0;
  logic [7:0] last_out = 8'h00;
  int         ready_mode = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_ch;
  logic [3:0] hold_idx;
  vec_t       vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic is_letter(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) return 1'b1;
`ifdef CIPHER_FEEDER_CASE_FOLD_EN
    if (c >= 8'h61 && c <= 8'h7A) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [7:0] upcase(input logic [7:0] c);
    return (c >= 8'h61) ? c - 8'h20 : c;
  endfunction

  // Reference: each message yields its letters in order, indexed by position mod KEY_LEN
  task automatic model_accept(input logic [7:0] c, input logic l);
    if (is_letter(c)) begin
      exp_q.push_back('{ch: upcase(c), idx: 4'(cur_pos % KEY_LEN)});
      cur_pos++;
    end else if (exp_err < 255) begin
      exp_err++;
    end
    if (l) begin
      exp_msgs++;
      cur_pos = 0;
    end
  endtask

  task automatic send_char(input logic [7:0] c, input logic l);
    int waited = 0;
    in_char  = c;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && waited < 500) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 1);
    end else begin
      @(posedge clock);
      model_accept(c, l);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last_on_end);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i], last_on_end && (i == s.len() - 1));
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || done_cnt != exp_msgs) && n < 3000) begin
      @(posedge clock);
      n++;
    end
    repeat (3) @(posedge clock);
    #1;
    chk({nm, "_drained"}, 32'(exp_q.size()), 0);
    chk({nm, "_done"}, 32'(done_cnt), 32'(exp_msgs));
    chk({nm, "_loads"}, 32'(load_cnt), 32'(exp_msgs));
    chk({nm, "_err"}, 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    plain_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       plain_ready = 1'b1;
        1:       plain_ready = 1'b0;
        default: plain_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (hold_pend) begin
        chk("hold_valid", 32'(plain_valid), 1);
        chk("hold_char", 32'(plain_char), 32'(hold_ch));
        chk("hold_idx", 32'(key_index), 32'(hold_idx));
      end
      hold_pend = plain_valid && !plain_ready;
      hold_ch   = plain_char;
      hold_idx  = key_index;
      if (key_load) begin
        load_cnt++;
        chk("load_idx", 32'(key_index), 0);
      end
      if (msg_done) done_cnt++;
      if (plain_valid && plain_ready) begin
        pop_cnt++;
        last_out = plain_char;
        chk("out_avail", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("out_char", 32'(plain_char), 32'(exp_q[0].ch));
          chk("out_idx", 32'(key_index), 32'(exp_q[0].idx));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int         pre_pop;
    logic [7:0] err_before;
    int         len;
    logic [7:0] c;

    vecs[0]  = '{8'h40, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{8'h41, 1'b1, 8'h41, 1'b0};
    vecs[2]  = '{8'h5A, 1'b1, 8'h5A, 1'b0};
    vecs[3]  = '{8'h5B, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{8'h35, 1'b0, 8'h00, 1'b1};
`ifdef CIPHER_FEEDER_CASE_FOLD_EN
    vecs[5]  = '{8'h61, 1'b1, 8'h41, 1'b0};
    vecs[6]  = '{8'h7A, 1'b1, 8'h5A, 1'b0};
`else
    vecs[5]  = '{8'h61, 1'b0, 8'h00, 1'b1};
    vecs[6]  = '{8'h7A, 1'b0, 8'h00, 1'b1};
`endif
    vecs[7]  = '{8'h60, 1'b0, 8'h00, 1'b1};
    vecs[8]  = '{8'h7B, 1'b0, 8'h00, 1'b1};
    vecs[9]  = '{8'h00, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{8'hFF, 1'b0, 8'h00, 1'b1};

    reset_n  = 1'b0;
    in_char  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_plain_valid", 32'(plain_valid), 0);
    chk("rst_key_load", 32'(key_load), 0);
    chk("rst_msg_done", 32'(msg_done), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_idx", 32'(key_index), 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Minimum latency from an idle, empty block
    ready_mode = 0;
    send_char(8'h51, 1'b1);
    chk("lat_k_load", 32'(key_load), 0);
    @(posedge clock); #1;
    chk("lat_k1_load", 32'(key_load), 1);
    chk("lat_k1_valid", 32'(plain_valid), 0);
    @(posedge clock); #1;
    chk("lat_k2_valid", 32'(plain_valid), 1);
    chk("lat_k2_char", 32'(plain_char), 32'h51);
    wait_idle("lat");

    pre_pop = pop_cnt;
    send_str("HI", 1'b1);
    wait_idle("hi");
    chk("hi_pops", 32'(pop_cnt - pre_pop), 2);
    chk("hi_last", 32'(last_out), 32'h49);

    send_str("AB1C", 1'b1);
    wait_idle("ab1c");
    chk("ab1c_err", 32'(err_count), 1);

    send_str("ABCDEFGHIJKL", 1'b1);
    wait_idle("twelve");

    for (int i = 0; i < 11; i++) begin
      pre_pop    = pop_cnt;
      err_before = err_count;
      send_char(vecs[i].ch, 1'b1);
      wait_idle("vec");
      chk("vec_out", 32'(pop_cnt - pre_pop), 32'(vecs[i].exp_out));
      if (vecs[i].exp_out) chk("vec_char", 32'(last_out), 32'(vecs[i].exp_char));
      chk("vec_err", 32'(err_count), 32'(err_before + 8'(vecs[i].exp_err)));
    end

    // Fill the FIFO with the consumer stalled, then release it
    ready_mode = 1;
    @(posedge clock); #1;
    send_str("STUVWXYZ", 1'b0);
    @(negedge clock);
    chk("full_ready", 32'(in_ready), 0);
    fork
      send_char(8'h4A, 1'b1);
      begin
        repeat (6) @(posedge clock);
        #1;
        chk("still_full", 32'(in_ready), 0);
        ready_mode = 0;
      end
    join
    wait_idle("full");

    // Reset in the middle of a buffered message
    ready_mode = 1;
    @(posedge clock); #1;
    send_str("MNO", 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("pre_rst_valid", 32'(plain_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(plain_valid), 0);
    chk("mid_rst_char", 32'(plain_char), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    chk("mid_rst_load", 32'(key_load), 0);
    chk("mid_rst_done", 32'(msg_done), 0);
    chk("mid_rst_err", 32'(err_count), 0);
    chk("mid_rst_idx", 32'(key_index), 0);
    exp_q.delete();
    cur_pos   = 0;
    exp_msgs  = 0;
    exp_err   = 0;
    load_cnt  = 0;
    done_cnt  = 0;
    hold_pend = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    ready_mode = 0;
    @(posedge clock); #1;
    send_str("XY", 1'b1);
    wait_idle("post_rst");

    // Randomized messages with random backpressure
    ready_mode = 2;
    for (int m = 0; m < 30; m++) begin
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) < 7) c = 8'h41 + 8'($urandom_range(0, 25));
        else c = 8'($urandom);
        send_char(c, i == len - 1);
        repeat ($urandom_range(0, 2)) @(posedge clock);
        #1;
      end
    end
    wait_idle("rand");

    // Error counter saturation
    ready_mode = 0;
    for (int i = 0; i < 260; i++) send_char(8'h23, 1'b0);
    send_char(8'h23, 1'b1);
    wait_idle("sat");
    chk("sat_err", 32'(err_count), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
